vsc8541_smi_init_seq: RTL and testbench

VSC8541_SMI_INIT_SEQ -- requirements
Module: vsc8541_smi_init_seq

---
 rtl/vsc8541_smi_init_seq.sv | 175 +++++++++++++++++
 tb/tb_vsc8541_smi_init_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vsc8541_smi_init_seq.sv
// ============================================================================
// vsc8541_smi_init_seq : table-driven SMI write / read-compare init sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module vsc8541_smi_init_seq #(
  parameter logic [4:0] PHY_ADDR    = 5'h00,
  parameter int         NUM_CMDS    = 8,
  parameter int         WAIT_CYCLES = 1000,
  parameter int         FRAME_MDC   = 34,
  parameter int         TIMEOUT_MDC = 64
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_mdc,
  input  logic        i_start,
  output logic [7:0]  o_cmd_idx,
  input  logic [21:0] i_cmd,
  output logic        o_smi_en,
  output logic        o_smi_mode,
  output logic [4:0]  o_smi_phy_addr,
  output logic [4:0]  o_smi_reg_addr,
  output logic [15:0] o_smi_data,
  input  logic        i_smi_dv,
  input  logic [15:0] i_smi_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [7:0]  o_err_idx,
  output logic [1:0]  o_err_code
);

  localparam int WW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int EMAX = (FRAME_MDC > TIMEOUT_MDC) ? FRAME_MDC : TIMEOUT_MDC;
  localparam int EW   = $clog2(EMAX + 1);

  localparam logic [WW-1:0] WAIT_LOAD    = WW'(WAIT_CYCLES);
  localparam logic [EW-1:0] FRAME_LAST   = EW'(FRAME_MDC - 1);
  localparam logic [EW-1:0] TIMEOUT_LAST = EW'(TIMEOUT_MDC - 1);
  localparam logic [7:0]    LAST_IDX     = 8'(NUM_CMDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FETCH, S_ISSUE, S_XFER, S_NEXT, S_FINISH, S_ERR
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [EW-1:0] edge_cnt;
  logic          fetch_2nd;
  logic          is_read;
  logic          mdc_q;
  logic          mdc_rise;

  assign mdc_rise = i_mdc & ~mdc_q;

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      edge_cnt       <= '0;
      fetch_2nd      <= 1'b0;
      is_read        <= 1'b0;
      mdc_q          <= 1'b0;
      o_cmd_idx      <= '0;
      o_smi_en       <= 1'b0;
      o_smi_mode     <= 1'b0;
      o_smi_phy_addr <= '0;
      o_smi_reg_addr <= '0;
      o_smi_data     <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_err_idx      <= '0;
      o_err_code     <= '0;
    end else begin
      mdc_q    <= i_mdc;
      o_smi_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            o_err_idx  <= '0;
            o_err_code <= '0;
            o_cmd_idx  <= '0;
            wait_cnt   <= WAIT_LOAD;
            o_busy     <= 1'b1;
            state      <= S_WAIT;
          end
        end
        // A load of 0 or 1 both leave after a single cycle.
        S_WAIT: begin
          if (wait_cnt <= WW'(1)) begin
            fetch_2nd <= 1'b0;
            state     <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        // First cycle lets a registered ROM catch up with o_cmd_idx.
        S_FETCH: begin
          if (fetch_2nd) begin
            is_read        <= i_cmd[21];
            o_smi_mode     <= ~i_cmd[21];
            o_smi_phy_addr <= PHY_ADDR;
            o_smi_reg_addr <= i_cmd[20:16];
            o_smi_data     <= i_cmd[15:0];
            o_smi_en       <= 1'b1;
            state          <= S_ISSUE;
          end else begin
            fetch_2nd <= 1'b1;
          end
        end
        S_ISSUE: begin
          edge_cnt <= '0;
          state    <= S_XFER;
        end
        // Read data beats the timeout edge when both land together.
        S_XFER: begin
          if (is_read) begin
            if (i_smi_dv) begin
              if (i_smi_data == o_smi_data) begin
                state <= S_NEXT;
              end else begin
                o_err_code <= 2'b01;
                state      <= S_ERR;
              end
            end else if (mdc_rise) begin
              if (edge_cnt == TIMEOUT_LAST) begin
                o_err_code <= 2'b10;
                state      <= S_ERR;
              end else begin
                edge_cnt <= edge_cnt + EW'(1);
              end
            end
          end else if (mdc_rise) begin
            if (edge_cnt == FRAME_LAST) begin
              state <= S_NEXT;
            end else begin
              edge_cnt <= edge_cnt + EW'(1);
            end
          end
        end
        S_NEXT: begin
          if (o_cmd_idx == LAST_IDX) begin
            state <= S_FINISH;
          end else begin
            o_cmd_idx <= o_cmd_idx + 8'd1;
            fetch_2nd <= 1'b0;
            state     <= S_FETCH;
          end
        end
        S_FINISH: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        S_ERR: begin
          o_error   <= 1'b1;
          o_err_idx <= o_cmd_idx;
          o_busy    <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vsc8541_smi_init_seq.sv
// ============================================================================
// tb_vsc8541_smi_init_seq : directed bench with registered ROM, MDC source
// and a transaction-level model of the expected SMI traffic and final status.
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vsc8541_smi_init_seq;

  localparam int         N    = 3;
  localparam int         WAIT = 10;
  localparam int         TMO  = 64;
  localparam logic [4:0] PHY  = 5'h03;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_mdc = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  o_cmd_idx;
  logic [21:0] i_cmd = '0;
  logic        o_smi_en, o_smi_mode;
  logic [4:0]  o_smi_phy_addr, o_smi_reg_addr;
  logic [15:0] o_smi_data;
  logic        i_smi_dv = 1'b0;
  logic [15:0] i_smi_data = '0;
  logic        o_busy, o_done, o_error;
  logic [7:0]  o_err_idx;
  logic [1:0]  o_err_code;

  vsc8541_smi_init_seq #(
    .PHY_ADDR(PHY), .NUM_CMDS(N), .WAIT_CYCLES(WAIT), .FRAME_MDC(34), .TIMEOUT_MDC(TMO)
  ) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_mdc(i_mdc), .i_start(i_start),
    .o_cmd_idx(o_cmd_idx), .i_cmd(i_cmd), .o_smi_en(o_smi_en), .o_smi_mode(o_smi_mode),
    .o_smi_phy_addr(o_smi_phy_addr), .o_smi_reg_addr(o_smi_reg_addr), .o_smi_data(o_smi_data),
    .i_smi_dv(i_smi_dv), .i_smi_data(i_smi_data), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_err_idx(o_err_idx), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [4:0]  ra;
    logic [15:0] d;
    logic [7:0]  idx;
  } txn_t;

  txn_t        expq[$];
  logic [21:0] tbl [0:N-1];
  logic [15:0] resp = '0;
  int          dv_edge = 0;
  logic        exp_done, exp_err;
  logic [1:0]  exp_code;
  logic [7:0]  exp_eidx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_en_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Registered ROM, MDC source (period 4 clk) and MDIO read responder.
  logic [7:0] idx_prev = '0;
  logic [7:0] mdc_cnt = '0;
  int         edges = 0;
  bit         active = 0, act_read = 0;
  always @(posedge clk) begin
    logic prev;
    #1;
    i_smi_dv = 1'b0;
    i_cmd    = (idx_prev < 8'(N)) ? tbl[idx_prev] : '0;
    idx_prev = o_cmd_idx;
    mdc_cnt  = mdc_cnt + 8'd1;
    prev     = i_mdc;
    i_mdc    = mdc_cnt[1];
    if (active && i_mdc && !prev) begin
      edges++;
      if (act_read && dv_edge != 0 && edges == dv_edge) begin
        i_smi_dv = 1'b1; i_smi_data = resp;
      end
      if (!act_read && edges == 5) begin
        i_smi_dv = 1'b1; i_smi_data = 16'hdead;  // stray pulse during a write
      end
    end
    if (o_smi_en) begin
      active = 1; act_read = !o_smi_mode; edges = 0;
    end
    if (!i_reset_n) active = 0;
  end

  // Compare process: every issued transaction against the model queue.
  logic en_prev = 1'b0, err_prev = 1'b0;
  always @(negedge clk) begin
    if (o_smi_en) begin
      chk("en_single_cycle", {63'd0, en_prev}, 64'd0);
      if (expq.size() == 0) begin
        chk("en_unexpected", 64'd1, 64'd0);
      end else begin
        txn_t t;
        t = expq.pop_front();
        chk("en_fields", {o_busy, o_smi_mode, o_smi_phy_addr, o_smi_reg_addr, o_smi_data, o_cmd_idx},
            {1'b1, t.mode, PHY, t.ra, t.d, t.idx});
        if (first_en_cyc < 0) first_en_cyc = cyc;
      end
    end
    if (o_error && !err_prev && exp_code == 2'b10) chk("timeout_edges", 64'(edges), 64'(TMO));
    en_prev  = o_smi_en;
    err_prev = o_error;
  end

  // Walk the table as the sequencer must: expected traffic and final status.
  task automatic model();
    expq.delete();
    exp_done = 1'b1; exp_err = 1'b0; exp_code = 2'b00; exp_eidx = 8'd0;
    for (int i = 0; i < N; i++) begin
      txn_t t;
      t.mode = !tbl[i][21]; t.ra = tbl[i][20:16]; t.d = tbl[i][15:0]; t.idx = 8'(i);
      expq.push_back(t);
      if (tbl[i][21]) begin
        if (dv_edge < 1 || dv_edge > TMO) begin
          exp_done = 0; exp_err = 1; exp_code = 2'b10; exp_eidx = 8'(i); return;
        end else if (resp != tbl[i][15:0]) begin
          exp_done = 0; exp_err = 1; exp_code = 2'b01; exp_eidx = 8'(i); return;
        end
      end
    end
  endtask

  int t0;
  task automatic start_seq(input bit hold);
    model();
    first_en_cyc = -1;
    @(negedge clk); i_start = 1'b1; t0 = cyc;
    @(negedge clk); if (!hold) i_start = 1'b0;
  endtask

  task automatic finish_seq(input string nm);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (o_done || o_error) break;
      @(negedge clk);
    end
    i_start = 1'b0;
    if (k == 3000) chk({nm, "_timeout"}, 64'd1, 64'd0);
    repeat (3) @(negedge clk);
    chk({nm, "_pending"}, 64'(expq.size()), 64'd0);
    chk({nm, "_status"}, {o_busy, o_done, o_error, o_err_code, o_err_idx},
        {1'b0, exp_done, exp_err, exp_code, exp_eidx});
  endtask

  task automatic load(input logic [21:0] a, input logic [21:0] b, input logic [21:0] c);
    tbl[0] = a; tbl[1] = b; tbl[2] = c;
  endtask

  localparam logic [48:0] ZERO_OUT = '0;

  initial begin
    int k;
    load({1'b0, 5'h00, 16'h1234}, {1'b0, 5'h1f, 16'habcd}, {1'b0, 5'h10, 16'h0001});
    exp_code = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_cmd_idx, o_smi_en, o_smi_mode, o_smi_phy_addr, o_smi_reg_addr, o_smi_data,
                          o_busy, o_done, o_error, o_err_idx, o_err_code}, ZERO_OUT);
    i_reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", {o_busy, o_smi_en}, 64'd0);

    // Three writes.
    start_seq(0);
    finish_seq("writes");
    chk("first_en_latency", 64'(first_en_cyc - t0), 64'd13);
    chk("writes_done_literal", {o_done, o_error}, 64'b10);

    // Read-and-compare, matching data.
    load({1'b0, 5'h04, 16'h0100}, {1'b1, 5'h1b, 16'h5aa5}, {1'b0, 5'h09, 16'h8000});
    resp = 16'h5aa5; dv_edge = 20;
    start_seq(0);
    finish_seq("read_ok");

    // Mismatching read data.
    resp = 16'h5aa4;
    start_seq(0);
    finish_seq("read_bad");
    chk("read_bad_literal", {o_error, o_err_code, o_err_idx}, {1'b1, 2'b01, 8'd1});

    // No read data at all.
    resp = 16'h5aa5; dv_edge = 0;
    start_seq(0);
    finish_seq("read_tmo");
    chk("read_tmo_literal", {o_error, o_err_code, o_err_idx}, {1'b1, 2'b10, 8'd1});

    // Read data exactly on the final allowed edge.
    dv_edge = TMO;
    start_seq(0);
    finish_seq("read_edge64");
    chk("read_edge64_literal", {o_done, o_error}, 64'b10);

    // Reset during the transfer of entry 1, then restart.
    load({1'b0, 5'h00, 16'h1234}, {1'b0, 5'h1f, 16'habcd}, {1'b0, 5'h10, 16'h0001});
    start_seq(0);
    for (k = 0; k < 2000; k++) begin
      if (o_smi_en && o_cmd_idx == 8'd1) break;
      @(negedge clk);
    end
    if (k == 2000) chk("wait_entry1", 64'd1, 64'd0);
    repeat (20) @(negedge clk);
    i_reset_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset_outputs", {o_cmd_idx, o_smi_en, o_smi_mode, o_smi_phy_addr, o_smi_reg_addr, o_smi_data,
                                 o_busy, o_done, o_error, o_err_idx, o_err_code}, ZERO_OUT);
    i_reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_midrun_reset", {o_busy, o_error}, 64'd0);
    start_seq(0);
    finish_seq("restart");

    // i_start held high through WAIT, XFER and the return to IDLE.
    start_seq(1);
    finish_seq("start_held");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
